// File: rtl/hdmi_fb_pkg.sv
// Shared types and helpers for the HDMI frame-buffer read scheduler.
package hdmi_fb_pkg;

    // Width of the per-frame word counter; holds an 11 x 11 bit product.
    localparam int WORDS_W = 22;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        CHECK = 3'd2,
        REQ   = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Length of the next burst: the remaining word count, capped at the burst limit.
    function automatic logic [7:0] burst_len(input logic [WORDS_W-1:0] words,
                                             input int                 max_len);
        logic [31:0] cap;
        cap = 32'(max_len);
        if (32'(words) < cap) begin
            return words[7:0];
        end
        return cap[7:0];
    endfunction

endpackage

// File: rtl/hdmi_fb_rd_scheduler.sv
// Per-frame read sequencer: flushes the HDMI read FIFO at each frame start,
// then walks the frame buffer linearly with one outstanding burst at a time,
// holding off requests while the FIFO lacks room for the next burst.
module hdmi_fb_rd_scheduler
    import hdmi_fb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int BURST_LEN  = 64,
    parameter int FIFO_DEPTH = 1024,
    parameter int LVL_W      = 11,
    parameter int FLUSH_CYC  = 4
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic              video_vs,
    input  logic [10:0]       h_disp,
    input  logic [10:0]       v_disp,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              fifo_empty,
    input  logic              rd_en,
    output logic              fifo_flush,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       underrun_cnt
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t               state_q;
    state_t               state_d;
    logic                 vs_d;
    logic                 frame_edge;
    logic [FC_W-1:0]      flush_cnt_q;
    logic                 flush_last;
    logic [WORDS_W-1:0]   words_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           len_q;
    logic [7:0]           cur_len;
    logic                 level_ok;
    logic                 pend_q;
    logic [15:0]          underrun_q;

    assign frame_edge = video_vs & ~vs_d;
    assign flush_last = (flush_cnt_q == FC_W'(FLUSH_CYC - 1));
    assign cur_len    = burst_len(words_q, BURST_LEN);
    assign level_ok   = (32'(fifo_level) + 32'(cur_len)) <= 32'(FIFO_DEPTH);

    assign fifo_flush   = (state_q == FLUSH);
    assign rd_req       = (state_q == REQ);
    assign rd_addr      = addr_q;
    assign rd_len       = len_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = (state_q == DONE);
    assign underrun_cnt = underrun_q;

    // State register plus the vsync delay used for rising-edge detection.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            vs_d    <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_d    <= video_vs;
        end
    end

    // Next-state logic; a new frame start always wins unless a burst is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_edge) state_d = FLUSH;
            end
            FLUSH: begin
                if (frame_edge)      state_d = FLUSH;
                else if (flush_last) state_d = CHECK;
            end
            CHECK: begin
                if (frame_edge)          state_d = FLUSH;
                else if (words_q == '0)  state_d = DONE;
                else if (level_ok)       state_d = REQ;
            end
            REQ: begin
                if (rd_ack)          state_d = WAIT;
                else if (frame_edge) state_d = FLUSH;
            end
            WAIT: begin
                if (rd_done) begin
                    if (pend_q || frame_edge) state_d = FLUSH;
                    else if (words_q == '0)   state_d = DONE;
                    else                      state_d = CHECK;
                end
            end
            DONE: begin
                state_d = frame_edge ? FLUSH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush timing, per-frame address/word bookkeeping and the pending-restart flag.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            flush_cnt_q <= '0;
            words_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            if (state_d == FLUSH && (state_q != FLUSH || frame_edge)) begin
                flush_cnt_q <= '0;
            end else if (state_q == FLUSH && !flush_last) begin
                flush_cnt_q <= flush_cnt_q + FC_W'(1);
            end

            if (state_q == FLUSH && flush_cnt_q == '0) begin
                words_q <= {11'd0, h_disp} * {11'd0, v_disp};
                addr_q  <= frame_base;
            end else if (state_q == REQ && rd_ack) begin
                words_q <= words_q - WORDS_W'(len_q);
                addr_q  <= addr_q + ADDR_W'(len_q);
            end

            if (state_q == CHECK && state_d == REQ) begin
                len_q <= cur_len;
            end

            if (state_d == FLUSH) begin
                pend_q <= 1'b0;
            end else if (frame_edge && (state_q == WAIT || (state_q == REQ && rd_ack))) begin
                pend_q <= 1'b1;
            end
        end
    end

    // Saturating count of display reads that found the FIFO empty.
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            underrun_q <= '0;
        end else if (rd_en && fifo_empty && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

endmodule
